// File: rtl/scc_dmem_arbiter_if.sv
// scc_dmem_arbiter_if: requester-side and memory-side signals of the data-memory arbiter.
// slave = arbiter view, master = requesters plus memory.
interface scc_dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata, p0_rdata;
    logic              p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata, p1_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              err_oob;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_addr, p1_wdata, mem_rdata,
        output p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, err_oob
    );
    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_addr, p1_wdata, mem_rdata,
        input  p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, err_oob
    );
endinterface

// File: rtl/scc_dmem_arbiter.sv
// scc_dmem_arbiter: shares one single-port synchronous data memory between core (p0) and dump engine (p1).
// Defining DMEM_ARB_STATS_EN adds grant/conflict counters.
module scc_dmem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int STARVE_MAX  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_en,
    scc_dmem_arbiter_if.slave    bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]          stat_p0_gnt,
    output logic [31:0]          stat_p1_gnt,
    output logic [31:0]          stat_conflict
`endif
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic              en, g0, g1, gnt, sel_we, sel_oob, oob0, oob1, rv;
    logic [ADDR_W-3:0] sel_idx;
    logic [DATA_W-1:0] sel_wdata, rd;
    logic [SW-1:0]     starve_cnt;
    logic              rd_vld, rd_own, rd_oob;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^{bus.p0_addr[1:0], bus.p1_addr[1:0]};

    // Gating with rst_n keeps every output low while reset is asserted.
    always_comb begin
        en        = clk_en & rst_n;
        oob0      = {2'b00, bus.p0_addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH_WORDS);
        oob1      = {2'b00, bus.p1_addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH_WORDS);
        g1        = en & bus.p1_req & (!bus.p0_req | (starve_cnt == SW'(STARVE_MAX)));
        g0        = en & bus.p0_req & !g1;
        gnt       = g0 | g1;
        sel_we    = g1 ? bus.p1_we : bus.p0_we;
        sel_oob   = g1 ? oob1 : oob0;
        sel_idx   = g1 ? bus.p1_addr[ADDR_W-1:2] : bus.p0_addr[ADDR_W-1:2];
        sel_wdata = g1 ? bus.p1_wdata : bus.p0_wdata;
        bus.p0_gnt    = g0;
        bus.p1_gnt    = g1;
        bus.mem_en    = gnt & !sel_oob;
        bus.mem_we    = bus.mem_en & sel_we;
        bus.mem_addr  = bus.mem_en ? sel_idx : '0;
        bus.mem_wdata = bus.mem_we ? sel_wdata : '0;
        rv            = rd_vld & en;
        rd            = rd_oob ? '0 : bus.mem_rdata;
        bus.p0_rvalid = rv & !rd_own;
        bus.p1_rvalid = rv & rd_own;
        bus.p0_rdata  = bus.p0_rvalid ? rd : '0;
        bus.p1_rdata  = bus.p1_rvalid ? rd : '0;
        bus.err_oob   = (gnt & sel_we & sel_oob) | (rv & rd_oob);
    end

    // Read tracker and starvation counter advance only on enabled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            rd_vld     <= 1'b0;
            rd_own     <= 1'b0;
            rd_oob     <= 1'b0;
        end else if (clk_en) begin
            starve_cnt <= (!bus.p1_req | g1) ? '0 :
                          (starve_cnt == SW'(STARVE_MAX)) ? starve_cnt : starve_cnt + 1'b1;
            rd_vld     <= gnt & !sel_we;
            rd_own     <= g1;
            rd_oob     <= sel_oob;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_p0_gnt   <= '0;
            stat_p1_gnt   <= '0;
            stat_conflict <= '0;
        end else if (clk_en) begin
            stat_p0_gnt   <= stat_p0_gnt + 32'(g0);
            stat_p1_gnt   <= stat_p1_gnt + 32'(g1);
            stat_conflict <= stat_conflict + 32'(bus.p0_req & bus.p1_req);
        end
    end
`endif
endmodule

// File: tb/tb_scc_dmem_arbiter.sv
// tb_scc_dmem_arbiter: directed and random checks of scc_dmem_arbiter against a transaction-level model.
module tb_scc_dmem_arbiter;
    localparam int AW = 32, DW = 32, DEPTH = 1024, SMAX = 4;

    logic clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1;
    int   total = 0, bad = 0;

    scc_dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] s_p0, s_p1, s_cf;
`endif

    scc_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_WORDS(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bus(bus)
`ifdef DMEM_ARB_STATS_EN
        , .stat_p0_gnt(s_p0), .stat_p1_gnt(s_p1), .stat_conflict(s_cf)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(int i);
        return (i == 100) ? 32'h32 : 32'(i) * 32'h01000193 + 32'h0BADF00D;
    endfunction

    logic [31:0] ram   [DEPTH];
    bit          ram_w [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr[9:0]]   <= bus.mem_wdata;
                ram_w[bus.mem_addr[9:0]] <= 1'b1;
            end else begin
                bus.mem_rdata <= ram_w[bus.mem_addr[9:0]] ? ram[bus.mem_addr[9:0]]
                                                          : init_val(int'(bus.mem_addr[9:0]));
            end
        end
    end

    typedef struct packed { bit port; bit oob; logic [31:0] data; } rd_t;
    rd_t         q[$];
    int          waited = 0;
    logic [31:0] ref_mem [int];
    bit          last_g0, last_g1;

    function automatic logic [31:0] ref_rd(int i);
        return ref_mem.exists(i) ? ref_mem[i] : init_val(i);
    endfunction

    task automatic chk(string tag, string what, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s observed=%h expected=%h", tag, what, obs, exp);
        end
    endtask

    task automatic drive(int p, bit req, bit we, logic [31:0] addr, logic [31:0] wd);
        if (p == 0) begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wd;
        end else begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wd;
        end
    endtask

    // One cycle: check outputs mid-cycle against the model, then advance the model at the edge.
    task automatic step(string tag);
        bit          en, g0, g1, g, gw, go, rv;
        int          gi;
        logic [31:0] gd;
        rd_t         r;
        logic [6:0]  ef;
        #1;
        if (!rst_n) begin
            q.delete();
            waited = 0;
        end
        en = clk_en && rst_n;
        g1 = en && bus.p1_req && (!bus.p0_req || waited >= SMAX);
        g0 = en && bus.p0_req && !g1;
        g  = g0 || g1;
        gw = g1 ? bus.p1_we : bus.p0_we;
        gi = int'((g1 ? bus.p1_addr : bus.p0_addr) >> 2);
        go = gi >= DEPTH;
        gd = g1 ? bus.p1_wdata : bus.p0_wdata;
        rv = en && q.size() > 0;
        r  = rv ? q[0] : '0;
        ef = {g0, g1, g && !go, g && !go && gw, rv && !r.port, rv && r.port, (g && gw && go) || (rv && r.oob)};
        chk(tag, "gnt0,gnt1,en,we,rv0,rv1,oob",
            {bus.p0_gnt, bus.p1_gnt, bus.mem_en, bus.mem_we, bus.p0_rvalid, bus.p1_rvalid, bus.err_oob}, ef);
        chk(tag, "p0_rdata", bus.p0_rdata, (rv && !r.port && !r.oob) ? r.data : 32'h0);
        chk(tag, "p1_rdata", bus.p1_rdata, (rv && r.port && !r.oob) ? r.data : 32'h0);
        if (g && !go) chk(tag, "mem_addr", bus.mem_addr, gi);
        if (g && !go && gw) chk(tag, "mem_wdata", bus.mem_wdata, gd);
        last_g0 = g0;
        last_g1 = g1;
        @(posedge clk);
        if (en) begin
            if (rv) void'(q.pop_front());
            if (g && !gw) q.push_back(rd_t'{g1, go, go ? 32'h0 : ref_rd(gi)});
            if (g && gw && !go) ref_mem[gi] = gd;
            waited = (bus.p1_req && !g1) ? ((waited < SMAX) ? waited + 1 : SMAX) : 0;
        end
        @(negedge clk);
    endtask

    task automatic rnd_req(int p);
        logic [31:0] a;
        a = ($urandom_range(0, 15) == 0) ? 32'((DEPTH + $urandom_range(0, 63)) << 2)
                                         : 32'($urandom_range(0, 31) << 2);
        drive(p, 1'b1, 1'($urandom_range(0, 1)), a, $urandom);
    endtask

    initial begin
        drive(0, 1'b1, 1'b0, 32'h190, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        step("reset_a");
        step("reset_b");
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        step("idle");
        drive(0, 1'b1, 1'b0, 32'h190, 32'h0);
        step("t1_gnt");
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1 chk("t1", "p0_rdata_const", bus.p0_rdata, 32'h32);
        step("t1_rv");
        drive(0, 1'b1, 1'b0, 32'h40, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h80, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step("t2");
            chk("t2", "p1_wins", last_g1, (i % 5) == 4);
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h1000, 32'h0);
        step("t3_gnt");
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        step("t3_rv");
        drive(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        step("t4_wr");
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h10, 32'h0);
        step("t4_rd");
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1 chk("t4", "p1_rdata_const", bus.p1_rdata, 32'hDEADBEEF);
        step("t4_rv");
        drive(0, 1'b1, 1'b0, 32'h20, 32'h0);
        step("t5_gnt");
        clk_en = 1'b0;
        drive(1, 1'b1, 1'b0, 32'h24, 32'h0);
        for (int i = 0; i < 3; i++) step("t5_frozen");
        clk_en = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        step("t5_rv");
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        step("t5_drain");
        drive(0, 1'b1, 1'b0, 32'h44, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h48, 32'h0);
        for (int i = 0; i < 3; i++) step("t6_pre");
        rst_n = 1'b0;
        step("t6_rst");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step("t6_post");
            chk("t6", "p1_wins", last_g1, i == 4);
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        step("t6_drain");
        for (int i = 0; i < 400; i++) begin
            if (last_g0) bus.p0_req = 1'b0;
            if (last_g1) bus.p1_req = 1'b0;
            if (!bus.p0_req && $urandom_range(0, 2) != 0) rnd_req(0);
            if (!bus.p1_req && $urandom_range(0, 2) != 0) rnd_req(1);
            clk_en = $urandom_range(0, 9) != 0;
            step("rnd");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
